systolic_array_kt: RTL

SYSTOLIC_ARRAY_KT -- requirements
Module: systolic_array_kt

---
 rtl/systolic_array_kt.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_array_kt.sv
// Weight-stationary NxN systolic GEMM engine with K-tile accumulation into a row buffer.
// Define SYSTOLIC_SAT_EN for saturating accumulation; the default build wraps.
module systolic_array_kt #(
   parameter int ARRAY_SIZE = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int MAX_M      = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [15:0]                      cfg_k_tiles,
   input  logic [$clog2(MAX_M):0]           cfg_m_rows,
   input  logic                             weight_load_en,
   input  logic [$clog2(ARRAY_SIZE)-1:0]    weight_load_col,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] weight_load_data,
   input  logic                             act_valid,
   output logic                             act_ready,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] act_data,
   output logic                             result_valid,
   input  logic                             result_ready,
   output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  result_data,
   output logic                             busy,
   output logic                             done
);
   localparam int N   = ARRAY_SIZE;
   localparam int DW  = DATA_WIDTH;
   localparam int AW  = ACC_WIDTH;
   localparam int CW  = $clog2(MAX_M) + 1;
   localparam int MW  = $clog2(MAX_M);
   localparam int PW  = 2*DW + $clog2(N) + 1;
   localparam int EW  = ((PW > AW) ? PW : AW) + 1;
   localparam int VL  = 2*N - 1;
   localparam int DCW = $clog2(2*N);
   localparam logic [DCW-1:0] DLAST = DCW'(2*N - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD_W = 3'd1;
   localparam logic [2:0] STREAM = 3'd2;
   localparam logic [2:0] DRAIN  = 3'd3;
   localparam logic [2:0] OUTPUT = 3'd4;

`ifdef SYSTOLIC_SAT_EN
   localparam logic signed [EW-1:0] SMAX = {{(EW-AW+1){1'b0}}, {(AW-1){1'b1}}};
   localparam logic signed [EW-1:0] SMIN = {{(EW-AW+1){1'b1}}, {(AW-1){1'b0}}};
`endif

   logic [2:0]     state_q, state_d;
   logic [15:0]    ktiles_q, ktiles_d, tile_q, tile_d;
   logic [CW-1:0]  mrows_q, mrows_d, row_q, row_d, out_q, out_d;
   logic [MW-1:0]  wr_q, wr_d;
   logic [N-1:0]   mask_q, mask_d, mask_nx;
   logic [DCW-1:0] drain_q, drain_d;
   logic [VL-1:0]  vld_q;
   logic           done_q, done_d;
   logic           xfer, wr_en;

   logic signed [DW-1:0] w_q   [N][N];
   logic signed [DW-1:0] a_q   [N][N];
   logic signed [DW-1:0] a_in  [N][N];
   logic signed [DW-1:0] sk_q  [N][N-1];
   logic signed [DW-1:0] skt   [N][N];
   logic signed [PW-1:0] p_q   [N][N];
   logic signed [PW-1:0] ps_in [N][N];
   logic signed [PW-1:0] ds_q  [N][N-1];
   logic signed [PW-1:0] tap   [N][N];
   logic signed [PW-1:0] col_out [N];
   logic signed [AW-1:0] buf_q [MAX_M][N];
   logic signed [AW-1:0] old_v [N];
   logic signed [EW-1:0] sum_v [N];
   logic signed [AW-1:0] nv    [N];

   assign act_ready    = (state_q == STREAM);
   assign result_valid = (state_q == OUTPUT);
   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign xfer         = act_valid && act_ready;
   assign wr_en        = vld_q[VL-1];

   always_comb begin
      for (int c = 0; c < N; c++)
         result_data[c*AW +: AW] = buf_q[out_q[MW-1:0]][c];
   end

   always_comb begin
      state_d  = state_q;
      ktiles_d = ktiles_q;
      mrows_d  = mrows_q;
      tile_d   = tile_q;
      row_d    = row_q;
      out_d    = out_q;
      mask_d   = mask_q;
      drain_d  = drain_q;
      done_d   = 1'b0;
      wr_d     = wr_en ? wr_q + MW'(1) : wr_q;
      mask_nx  = mask_q;
      if (weight_load_en) mask_nx[weight_load_col] = 1'b1;
      unique case (state_q)
         IDLE: if (start) begin
            state_d  = LOAD_W;
            ktiles_d = (cfg_k_tiles == 16'd0) ? 16'd1 : cfg_k_tiles;
            mrows_d  = (cfg_m_rows == '0) ? CW'(1) :
                       (cfg_m_rows > CW'(MAX_M)) ? CW'(MAX_M) : cfg_m_rows;
            tile_d   = '0;
            mask_d   = '0;
         end
         LOAD_W: begin
            mask_d = mask_nx;
            if (&mask_nx) begin
               state_d = STREAM;
               row_d   = '0;
               wr_d    = '0;
            end
         end
         STREAM: if (xfer) begin
            row_d = row_q + CW'(1);
            if (row_d == mrows_q) begin
               state_d = DRAIN;
               drain_d = '0;
            end
         end
         DRAIN: begin
            drain_d = drain_q + DCW'(1);
            if (drain_q == DLAST) begin
               if (tile_q + 16'd1 < ktiles_q) begin
                  state_d = LOAD_W;
                  tile_d  = tile_q + 16'd1;
                  mask_d  = '0;
               end else begin
                  state_d = OUTPUT;
                  out_d   = '0;
               end
            end
         end
         OUTPUT: if (result_ready) begin
            out_d = out_q + CW'(1);
            if (out_d == mrows_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ktiles_q <= '0;
         mrows_q  <= '0;
         tile_q   <= '0;
         row_q    <= '0;
         out_q    <= '0;
         wr_q     <= '0;
         mask_q   <= '0;
         drain_q  <= '0;
         vld_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ktiles_q <= ktiles_d;
         mrows_q  <= mrows_d;
         tile_q   <= tile_d;
         row_q    <= row_d;
         out_q    <= out_d;
         wr_q     <= wr_d;
         mask_q   <= mask_d;
         drain_q  <= drain_d;
         vld_q    <= {vld_q[VL-2:0], xfer};
         done_q   <= done_d;
      end
   end

   // Row element k enters k cycles late; column c leaves N-1-c cycles late.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         skt[k][0] = xfer ? act_data[k*DW +: DW] : '0;
         for (int j = 1; j < N; j++) skt[k][j] = sk_q[k][j-1];
         a_in[k][0] = skt[k][k];
         for (int c = 1; c < N; c++) a_in[k][c] = a_q[k][c-1];
      end
      for (int c = 0; c < N; c++) begin
         ps_in[0][c] = '0;
         for (int k = 1; k < N; k++) ps_in[k][c] = p_q[k-1][c];
         tap[c][0] = p_q[N-1][c];
         for (int j = 1; j < N; j++) tap[c][j] = ds_q[c][j-1];
         col_out[c] = tap[c][N-1-c];
      end
   end

   always_comb begin
      for (int c = 0; c < N; c++) begin
         old_v[c] = (tile_q == 16'd0) ? '0 : buf_q[wr_q][c];
         sum_v[c] = EW'(old_v[c]) + EW'(col_out[c]);
`ifdef SYSTOLIC_SAT_EN
         if (sum_v[c] > SMAX)      nv[c] = SMAX[AW-1:0];
         else if (sum_v[c] < SMIN) nv[c] = SMIN[AW-1:0];
         else                      nv[c] = sum_v[c][AW-1:0];
`else
         nv[c] = sum_v[c][AW-1:0];
`endif
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         sk_q[k][0] <= skt[k][0];
         for (int j = 1; j < N-1; j++) sk_q[k][j] <= sk_q[k][j-1];
         for (int c = 0; c < N; c++) begin
            a_q[k][c] <= a_in[k][c];
            p_q[k][c] <= ps_in[k][c] + PW'(a_in[k][c]) * PW'(w_q[k][c]);
         end
         if (state_q == LOAD_W && weight_load_en)
            w_q[k][weight_load_col] <= weight_load_data[k*DW +: DW];
      end
      for (int c = 0; c < N; c++) begin
         ds_q[c][0] <= p_q[N-1][c];
         for (int j = 1; j < N-1; j++) ds_q[c][j] <= ds_q[c][j-1];
         if (wr_en) buf_q[wr_q][c] <= nv[c];
      end
   end
endmodule
